// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared Mini_NPU datapath definitions: pixel width and type,
//                signed max helper, and the max-pool row-phase state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

  localparam int NPU_DATA_W = 22;

  // Pixel type shared with the activation stage.
  typedef logic signed [NPU_DATA_W-1:0] npu_pixel_t;

  // Row phase of the 2x2 pooler: even rows fill the line buffer, odd rows emit.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } pool_state_t;

  // Signed two's-complement maximum; ties return the common value.
  function automatic npu_pixel_t npu_max(input npu_pixel_t a, input npu_pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/max_pool_2x2_if.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2_if
//  Description : Pixel-in / result-out stream bundle for the 2x2 max-pool
//                stage.
//                  pixel_valid  : input pixel qualifier
//                  pixel_in     : signed input pixel, raster order
//                  result_valid : one-cycle pulse per pooled pixel
//                  result_out   : signed pooled maximum
//                  frame_done   : last pooled pixel of a frame (only when
//                                 MAXPOOL_FRAME_DONE_EN is defined)
//                master = upstream/consumer side, slave = the pooler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface max_pool_2x2_if
  import npu_pkg::*;
#(
  parameter int DATA_W = NPU_DATA_W
) ();

  logic                     pixel_valid;
  logic signed [DATA_W-1:0] pixel_in;
  logic                     result_valid;
  logic signed [DATA_W-1:0] result_out;
`ifdef MAXPOOL_FRAME_DONE_EN
  logic                     frame_done;

  modport master (
    output pixel_valid, pixel_in,
    input  result_valid, result_out, frame_done
  );

  modport slave (
    input  pixel_valid, pixel_in,
    output result_valid, result_out, frame_done
  );
`else
  modport master (
    output pixel_valid, pixel_in,
    input  result_valid, result_out
  );

  modport slave (
    input  pixel_valid, pixel_in,
    output result_valid, result_out
  );
`endif

endinterface
`default_nettype wire

// File: rtl/max_pool_2x2_pool_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pool_line_buf
//  Description : Line buffer holding one horizontal pair-maximum per output
//                column of the pooled row.
//                  clk   : clock
//                  we    : write enable (synchronous write)
//                  waddr : write address
//                  wdata : write data
//                  raddr : read address (combinational read)
//                  rdata : read data
//                Contents are not reset: every entry is rewritten on an even
//                row before it is read on the following odd row.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buf #(
  parameter int DEPTH  = 14,
  parameter int DATA_W = 22,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2
//  Description : Streaming 2x2 / stride-2 max-pooling of a raster-order
//                IMG_W x IMG_H feature map, no backpressure.
//                  clk  : clock
//                  rst  : synchronous, active-high reset
//                  bus  : max_pool_2x2_if.slave (pixel_valid, pixel_in,
//                         result_valid, result_out[, frame_done])
//                Optional feature macro: MAXPOOL_FRAME_DONE_EN adds a
//                frame_done pulse alongside the last pooled pixel of a frame.
//                IMG_W and IMG_H must be even and >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_pool_2x2
  import npu_pkg::*;
#(
  parameter int DATA_W = NPU_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic          clk,
  input  logic          rst,
  max_pool_2x2_if.slave bus
);

  localparam int C_COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int C_ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int C_HALF_W = IMG_W / 2;
  localparam int C_ADDR_W = (C_HALF_W > 1) ? $clog2(C_HALF_W) : 1;

  logic [C_COL_W-1:0]       r_col;
  logic [C_ROW_W-1:0]       r_row;
  logic signed [DATA_W-1:0] r_h_max;
  logic                     r_result_valid;
  logic signed [DATA_W-1:0] r_result_out;
  pool_state_t              r_state;
  pool_state_t              w_state_next;

  logic                     w_col_last;
  logic                     w_pair_done;
  logic                     w_lb_we;
  logic                     w_emit;
  logic [C_ADDR_W-1:0]      w_lb_addr;
  logic signed [DATA_W-1:0] w_lb_rdata;
  logic signed [DATA_W-1:0] w_pair;
  logic signed [DATA_W-1:0] w_pool;

  assign w_col_last  = (r_col == C_COL_W'(IMG_W - 1));
  // A pair completes on every valid odd column; reset swallows the input.
  assign w_pair_done = bus.pixel_valid && r_col[0] && !rst;
  assign w_lb_addr   = C_ADDR_W'(r_col >> 1);

  // Signed maxima: use the shared helper when the width matches the NPU
  // pixel type, otherwise an equivalent width-generic compare.
  generate
    if (DATA_W == NPU_DATA_W) begin : g_max_pkg
      assign w_pair = npu_max(r_h_max, bus.pixel_in);
      assign w_pool = npu_max(w_lb_rdata, w_pair);
    end else begin : g_max_generic
      assign w_pair = (bus.pixel_in > r_h_max) ? bus.pixel_in : r_h_max;
      assign w_pool = (w_pair > w_lb_rdata) ? w_pair : w_lb_rdata;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Raster position counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.pixel_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= (r_row == C_ROW_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Left pixel of the current horizontal pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_max <= '0;
    end else if (bus.pixel_valid && !r_col[0]) begin
      r_h_max <= bus.pixel_in;
    end
  end

  // --------------------------------------------------------------------------
  // Row phase FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lb_we      = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_lb_we = w_pair_done;
        if (bus.pixel_valid && w_col_last) begin
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_emit = w_pair_done;
        if (bus.pixel_valid && w_col_last) begin
          w_state_next = ST_FILL;
        end
      end
      default: begin
        w_state_next = ST_FILL;
      end
    endcase
  end

  pool_line_buf #(
    .DEPTH  (C_HALF_W),
    .DATA_W (DATA_W),
    .ADDR_W (C_ADDR_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (w_lb_we),
    .waddr (w_lb_addr),
    .wdata (w_pair),
    .raddr (w_lb_addr),
    .rdata (w_lb_rdata)
  );

  // --------------------------------------------------------------------------
  // Output registers: result_out holds between pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_valid <= 1'b0;
      r_result_out   <= '0;
    end else begin
      r_result_valid <= w_emit;
      if (w_emit) begin
        r_result_out <= w_pool;
      end
    end
  end

  assign bus.result_valid = r_result_valid;
  assign bus.result_out   = r_result_out;

`ifdef MAXPOOL_FRAME_DONE_EN
  logic r_frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_emit && w_col_last && (r_row == C_ROW_W'(IMG_H - 1));
    end
  end

  assign bus.frame_done = r_frame_done;
`endif

endmodule
`default_nettype wire

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2×2, stride-2 max-pooling stage placed directly downstream of the ReLU activation stage in the Mini_NPU datapath. It consumes the activation's raster-order `valid`/`data` pixel stream of an `IMG_W`×`IMG_H` feature map. It emits one pooled pixel per 2×2 window, for `(IMG_W/2)×(IMG_H/2)` pixels per frame. There is no backpressure; upstream may insert idle cycles anywhere.

## Interface
Parameters:
- `DATA_W`, default 22: signed pixel width, matching the activation output.
- `IMG_W`, default 28: input columns. Must be even and ≥ 2.
- `IMG_H`, default 28: input rows. Must be even and ≥ 2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `pixel_valid`  in  1: `pixel_in` is valid this cycle.
- `pixel_in`  in  `DATA_W`, signed: input pixel, raster order (row-major, column 0 first).
- `result_valid`  out  1: `result_out` is valid. Single-cycle pulse per pooled pixel.
- `result_out`  out  `DATA_W`, signed: pooled maximum.
- `frame_done`  out  1: only with `MAXPOOL_FRAME_DONE_EN`. See Configuration.

## Operation
- **Counters.** `col` (0..`IMG_W`-1) and `row` (0..`IMG_H`-1) advance only on cycles with `pixel_valid`=1.
  - `col` wraps to 0 at `IMG_W`-1, and `row` increments on that wrap.
  - `row` wraps to 0 after `IMG_H`-1, so the next frame starts seamlessly.
- **Horizontal pair.**
  - On a valid even `col`, store `pixel_in` in `h_max`.
  - On a valid odd `col`, compute `pair = max(h_max, pixel_in)`.
- **Row phase FSM**, two states selected by `row[0]`:
  - `FILL` (even row): on each valid odd `col`, write `pair` into `line_buf[col>>1]`. `IMG_W/2` entries, `DATA_W` bits each.
  - `EMIT` (odd row): on each valid odd `col`, register `result_out ← max(line_buf[col>>1], pair)` and `result_valid ← 1`.
  - `FILL`→`EMIT` on the valid pixel at `col`=`IMG_W`-1 of an even row. `EMIT`→`FILL` on the same condition in an odd row.
- **Arithmetic.** All comparisons are signed two's complement. Output width equals input width, so there is no growth or saturation. Equal values give that value.
- **Negative inputs.** These are legal and pooled correctly even though the ReLU upstream normally prevents them.
- **Line buffer.** No clear is needed: every entry is written in `FILL` before it is read in `EMIT`.
- **Gaps.** Any number of idle cycles between valid pixels does not change results. `h_max` and `line_buf` hold their values while idle.

## Timing
- Latency: `result_valid` rises exactly 1 clk after the valid input at (odd `row`, odd `col`).
- Throughput: accepts 1 pixel/clk sustained; emits at most 1 result per 2 clks.
- `result_valid` is low in every cycle not directly following a qualifying input.
- `result_out` holds its last value while `result_valid` is 0.
- Reset values (`rst`=1 at a clk edge):
  - `col`, `row`, `h_max`, `result_out`, `frame_done` are 0.
  - `result_valid` is 0.
  - FSM is `FILL`.
  - `line_buf` is not reset.
- Reset mid-frame: the partial frame is discarded. The first valid pixel after `rst` deasserts is treated as (row 0, col 0).
- `pixel_valid`=1 while `rst`=1: the input is ignored.
- Last pixel of a frame (`row`=`IMG_H`-1, `col`=`IMG_W`-1):
  - The final result is emitted the next clk.
  - The counters wrap to 0 in the same cycle, so a valid pixel in that next clk counts as the first pixel of the new frame.

## Configuration
- `MAXPOOL_FRAME_DONE_EN` defined:
  - Adds output `frame_done`, a 1-clk pulse coincident with `result_valid` for the final pooled pixel of each frame.
  - Reset value is 0.
- `MAXPOOL_FRAME_DONE_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `npu_pkg` holds:
  - `localparam NPU_DATA_W = 22`
  - `typedef logic signed [NPU_DATA_W-1:0] npu_pixel_t`
  - function `npu_max(a, b)`, a signed max.
  - The activation stage uses the same type.
- Sub-module `pool_line_buf`:
  - Depth `IMG_W/2`, width `DATA_W`.
  - Synchronous write (`we`, `waddr`, `wdata`), combinational read (`raddr` → `rdata`).
  - Counters, FSM, compare and output registers stay in `max_pool_2x2`.

## Test plan
All scenarios use `IMG_W`=4 and `IMG_H`=4 unless stated.
- **Ramp.** Stream 1..16 back-to-back → `result_out` = 6, 8, 14, 16. Each arrives 1 clk after inputs 6, 8, 14, 16 respectively. There are exactly 4 `result_valid` pulses.
- **Signed.** All 16 inputs = -5, except the input at (1,1) = -2 → results -2, -5, -5, -5.
- **Gaps.** Ramp 1..16 with 3 idle cycles after every valid pixel → same values 6, 8, 14, 16. `result_out` is stable during gaps.
- **Reset mid-frame.** Send 10 ramp pixels, pulse `rst` 1 clk, then a full ramp 1..16 → only 6, 8, 14, 16 after reset. `result_valid` is 0 in the reset cycle.
- **Back-to-back frames.** Ramp 1..16 followed immediately by 101..116 → 6, 8, 14, 16, 106, 108, 114, 116.
  - With `MAXPOOL_FRAME_DONE_EN`: `frame_done` pulses alongside the 16 and 116 results only.
- **Wide config.** `IMG_W`=28, `IMG_H`=28 with a random stream → 196 results that match the reference model bit-exactly.
